// File: rtl/floo_mcast_fork_pkg.sv
// Shared types for the multicast fork: route directions, port count and flit payloads.
package floo_mcast_fork_pkg;

  localparam int unsigned NumRoutes = 5;

  typedef enum logic [2:0] {
    Eject = 3'd0,
    North = 3'd1,
    East  = 3'd2,
    South = 3'd3,
    West  = 3'd4
  } route_e;

  localparam int unsigned NarrowFlitWidth = 8;
  localparam int unsigned WideFlitWidth   = 64;

  typedef logic [NarrowFlitWidth-1:0] narrow_flit_t;
  typedef logic [WideFlitWidth-1:0]   wide_flit_t;

endpackage

// File: rtl/floo_mcast_fork.sv
// Multicast fork: replicates each input flit onto every selected output port and
// holds the input until all selected ports have accepted; selection locked per packet.
module floo_mcast_fork #(
  parameter int unsigned NumRoutes = floo_mcast_fork_pkg::NumRoutes,
  parameter type         flit_t    = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  flit_t                data_i,
  input  logic                 last_i,
  input  logic [NumRoutes-1:0] route_sel_i,
  output logic [NumRoutes-1:0] valid_o,
  input  logic [NumRoutes-1:0] ready_i,
  output flit_t                data_o [NumRoutes],
  output logic                 busy_o,
  output logic                 drop_o
);
  import floo_mcast_fork_pkg::*;

  typedef enum logic {
    HEAD  = 1'b0,
    BURST = 1'b1
  } fork_state_e;

  fork_state_e          state_q, state_d;
  logic [NumRoutes-1:0] sel_q, sent_q;
  logic [NumRoutes-1:0] sel, hs, port_ok;
  logic                 done;

  // Per-port replication; a port is satisfied once deselected, already served, or handshaking now.
  for (genvar r = 0; r < NumRoutes; r++) begin : g_port
    assign valid_o[r] = valid_i & sel[r] & ~sent_q[r];
    assign hs[r]      = valid_o[r] & ready_i[r];
    assign port_ok[r] = ~sel[r] | sent_q[r] | hs[r];
    assign data_o[r]  = data_i;
  end

  assign done = valid_i & (&port_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HEAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (done) begin
      state_d = last_i ? HEAD : BURST;
    end
  end

  always_comb begin
    sel     = (state_q == HEAD) ? route_sel_i : sel_q;
    ready_o = done;
    drop_o  = valid_i & (state_q == HEAD) & ~(|route_sel_i);
    busy_o  = (state_q == BURST);
  end

  // Head selection lock and per-port served flags; a completed flit clears all flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q  <= '0;
      sent_q <= '0;
    end else if (done) begin
      sent_q <= '0;
      if (state_q == HEAD) begin
        sel_q <= route_sel_i;
      end
    end else if (valid_i) begin
      sent_q <= sent_q | hs;
    end
  end

endmodule

// File: tb/tb_floo_mcast_fork.sv
// Directed table-driven bench for floo_mcast_fork plus a hand-written reset-mid-packet sequence.
module tb_floo_mcast_fork;
  import floo_mcast_fork_pkg::*;

  localparam int unsigned NR = 5;

  logic                 clk;
  logic                 rst_ni;
  logic                 valid_i;
  logic                 ready_o;
  narrow_flit_t         data_i;
  logic                 last_i;
  logic [NR-1:0]        route_sel_i;
  logic [NR-1:0]        valid_o;
  logic [NR-1:0]        ready_i;
  narrow_flit_t         data_o [NR];
  logic                 busy_o;
  logic                 drop_o;

  int n_cmp;
  int n_bad;

  floo_mcast_fork #(
    .NumRoutes (NR),
    .flit_t    (narrow_flit_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .last_i      (last_i),
    .route_sel_i (route_sel_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .drop_o      (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          l;
    logic [NR-1:0] sel;
    logic [NR-1:0] rdy;
    logic [7:0]    d;
    logic [NR-1:0] evo;
    logic          ero;
    logic          edrop;
    logic          ebusy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic l, input logic [NR-1:0] sel,
                     input logic [NR-1:0] rdy, input logic [7:0] d,
                     input logic [NR-1:0] evo, input logic ero,
                     input logic edrop, input logic ebusy);
    vec_t t;
    t.v = v; t.l = l; t.sel = sel; t.rdy = rdy; t.d = d;
    t.evo = evo; t.ero = ero; t.edrop = edrop; t.ebusy = ebusy;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [7:0] exp);
    for (int r = 0; r < int'(NR); r++) begin
      chk($sformatf("%s data_o[%0d]", tag, r), 32'(data_o[r]), 32'(exp));
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [NR-1:0] sel,
                       input logic [NR-1:0] rdy, input logic [7:0] d);
    valid_i = v; last_i = l; route_sel_i = sel; ready_i = rdy; data_i = d;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 8'h00);

    //   v  l  sel       rdy       data   valid_o   ro  drop busy
    // unicast, then idle
    add(1, 1, 5'b00100, 5'b11111, 8'h11, 5'b00100, 1, 0, 0);
    add(0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0);
    // eager fork with staggered ready
    add(1, 1, 5'b10011, 5'b00001, 8'h22, 5'b10011, 0, 0, 0);
    add(1, 1, 5'b10011, 5'b00000, 8'h22, 5'b10010, 0, 0, 0);
    add(1, 1, 5'b10011, 5'b00010, 8'h22, 5'b10010, 0, 0, 0);
    add(1, 1, 5'b10011, 5'b10000, 8'h22, 5'b10000, 1, 0, 0);
    add(0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0);
    // wormhole lock: body flits carry a different selection
    add(1, 0, 5'b01010, 5'b11111, 8'h31, 5'b01010, 1, 0, 0);
    add(1, 0, 5'b10000, 5'b11111, 8'h32, 5'b01010, 1, 0, 1);
    add(1, 1, 5'b10000, 5'b11111, 8'h33, 5'b01010, 1, 0, 1);
    add(0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0);
    // valid dropping mid-flit keeps sent flags; head completes then tail
    add(1, 0, 5'b01010, 5'b00010, 8'h41, 5'b01010, 0, 0, 0);
    add(0, 0, 5'b01010, 5'b11111, 8'h41, 5'b00000, 0, 0, 0);
    add(1, 0, 5'b01010, 5'b00000, 8'h41, 5'b01000, 0, 0, 0);
    add(1, 0, 5'b01010, 5'b01000, 8'h41, 5'b01000, 1, 0, 0);
    add(1, 1, 5'b00001, 5'b11111, 8'h42, 5'b01010, 1, 0, 1);
    add(0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0);
    // empty selection: 3-flit packet discarded
    add(1, 0, 5'b00000, 5'b11111, 8'h51, 5'b00000, 1, 1, 0);
    add(1, 0, 5'b11111, 5'b11111, 8'h52, 5'b00000, 1, 0, 1);
    add(1, 1, 5'b11111, 5'b00000, 8'h53, 5'b00000, 1, 0, 1);
    add(0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0);
    // back-to-back single-flit packets
    add(1, 1, 5'b00001, 5'b11111, 8'h61, 5'b00001, 1, 0, 0);
    add(1, 1, 5'b11000, 5'b11111, 8'h62, 5'b11000, 1, 0, 0);
    // single-flit empty selection
    add(1, 1, 5'b00000, 5'b11111, 8'h71, 5'b00000, 1, 1, 0);
    add(0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("reset valid_o", 32'(valid_o), 32'h0);
    chk("reset ready_o", 32'(ready_o), 32'h0);
    chk("reset busy_o",  32'(busy_o),  32'h0);
    chk("reset drop_o",  32'(drop_o),  32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].l, vecs[i].sel, vecs[i].rdy, vecs[i].d);
      #1;
      chk($sformatf("v%0d valid_o", i), 32'(valid_o), 32'(vecs[i].evo));
      chk($sformatf("v%0d ready_o", i), 32'(ready_o), 32'(vecs[i].ero));
      chk($sformatf("v%0d drop_o", i),  32'(drop_o),  32'(vecs[i].edrop));
      chk($sformatf("v%0d busy_o", i),  32'(busy_o),  32'(vecs[i].ebusy));
      if (vecs[i].v) chk_data($sformatf("v%0d", i), vecs[i].d);
    end

    // reset mid-packet: head consumed, body partially sent to port 1
    @(negedge clk);
    drive(1, 0, 5'b00110, 5'b11111, 8'h81);
    #1;
    chk("rst head ready_o", 32'(ready_o), 32'h1);
    @(negedge clk);
    drive(1, 0, 5'b10000, 5'b00010, 8'h82);
    #1;
    chk("rst body valid_o", 32'(valid_o), 32'(5'b00110));
    chk("rst body ready_o", 32'(ready_o), 32'h0);
    chk("rst body busy_o",  32'(busy_o),  32'h1);
    @(negedge clk);
    drive(0, 0, 5'b00000, 5'b00000, 8'h00);
    #1;
    chk("rst pre busy_o", 32'(busy_o), 32'h1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst async busy_o",  32'(busy_o),  32'h0);
    chk("rst async valid_o", 32'(valid_o), 32'h0);
    chk("rst async ready_o", 32'(ready_o), 32'h0);
    chk("rst async drop_o",  32'(drop_o),  32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    drive(1, 1, 5'b01010, 5'b11111, 8'h91);
    #1;
    chk("post rst valid_o", 32'(valid_o), 32'(5'b01010));
    chk("post rst ready_o", 32'(ready_o), 32'h1);
    chk("post rst busy_o",  32'(busy_o),  32'h0);
    chk_data("post rst", 8'h91);
    @(negedge clk);
    drive(0, 0, 5'b00000, 5'b00000, 8'h00);
    #1;
    chk("post rst idle busy_o", 32'(busy_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
